axi4_chan_buffer: RTL and testbench

AXI4_CHAN_BUFFER -- requirements
Module: axi4_chan_buffer

---
 rtl/axi4_chan_buffer.sv | 141 ++++++++++++++
 tb/tb_axi4_chan_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_chan_buffer.sv
// Elastic buffer for one AXI4 channel: in-order FIFO with optional store-and-forward on last.
// Define AXI4_CHAN_BUFFER_STATS_EN to build the high-water occupancy register.
module axi4_chan_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [$clog2(DEPTH):0]     high_water
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Each entry holds {last, data}.
    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                full;
    logic                push;
    logic                pop;

    // Handshake: a beat moves on any rising edge where valid && ready; valid never waits
    // on ready, and ready is derived from registered occupancy only.
    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !rst && !full;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = rst ? '0 : count_q;

    assign {out_last, out_data} = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: contents are unobservable while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
        end
    end

    generate
        if (PACKET_MODE == 0) begin : g_cut_through
            assign out_valid = !rst && (count_q != '0);
        end else begin : g_store_forward
            logic [CW-1:0] last_cnt_q, last_cnt_d;
            logic          hold_q, hold_d;
            logic          in_last_push;
            logic          out_last_pop;

            assign in_last_push = push && in_last;
            assign out_last_pop = pop && out_last;

            // Release when a whole burst is stored, or when full so long bursts cannot deadlock;
            // hold_q keeps an offered beat valid until it is taken.
            assign out_valid = !rst && (count_q != '0) &&
                               ((last_cnt_q != '0) || full || hold_q);

            always_comb begin
                last_cnt_d = last_cnt_q;
                if (in_last_push && !out_last_pop) begin
                    last_cnt_d = last_cnt_q + CW'(1);
                end else if (out_last_pop && !in_last_push) begin
                    last_cnt_d = last_cnt_q - CW'(1);
                end
                hold_d = out_valid && !out_ready;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    last_cnt_q <= '0;
                    hold_q     <= 1'b0;
                end else begin
                    last_cnt_q <= last_cnt_d;
                    hold_q     <= hold_d;
                end
            end
        end
    endgenerate

`ifdef AXI4_CHAN_BUFFER_STATS_EN
    logic [CW-1:0] high_water_q, high_water_d;

    always_comb begin
        high_water_d = high_water_q;
        if (count_d > high_water_q) begin
            high_water_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign high_water = rst ? '0 : high_water_q;
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_axi4_chan_buffer.sv
// Bench for axi4_chan_buffer: one cut-through and one store-and-forward instance,
// checked against a queue-based model of the buffer rules.
module tb_axi4_chan_buffer;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]         in_valid = '0;
  logic [1:0]         in_ready;
  logic [1:0][DW-1:0] in_data = '0;
  logic [1:0]         in_last = '0;
  logic [1:0]         out_valid;
  logic [1:0]         out_ready = '0;
  logic [1:0][DW-1:0] out_data;
  logic [1:0]         out_last;
  logic [1:0][CW-1:0] occupancy;
  logic [1:0][CW-1:0] high_water;
  logic [1:0][1:0]    ready_mode = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0] exp_q0[$];
  logic [DW:0] exp_q1[$];
  bit              model_ok = 1'b0;
  logic [1:0]      sticky = '0;
  logic [1:0][DW:0] held_beat;
  int model_max[2];
  int dut_peak[2];

  always #5 clk = ~clk;

  axi4_chan_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .occupancy(occupancy[0]), .high_water(high_water[0])
  );

  axi4_chan_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .occupancy(occupancy[1]), .high_water(high_water[1])
  );

  function automatic void chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", name, i, $time, act, exp);
    end
  endfunction

  function automatic int q_size(int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic int q_lastcnt(int i);
    int c = 0;
    if (i == 0) foreach (exp_q0[k]) c += int'(exp_q0[k][DW]);
    else        foreach (exp_q1[k]) c += int'(exp_q1[k][DW]);
    return c;
  endfunction

  function automatic void q_push(int i, logic [DW:0] v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic logic [DW:0] q_pop(int i);
    return (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  function automatic void q_clear(int i);
    if (i == 0) exp_q0.delete();
    else        exp_q1.delete();
  endfunction

  // Monitor: checks the state left by the last edge, then books the transfers of the next edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("rst_out_valid", i, 32'(out_valid[i]), 0);
        chk("rst_in_ready", i, 32'(in_ready[i]), 0);
        chk("rst_occupancy", i, 32'(occupancy[i]), 0);
        chk("rst_high_water", i, 32'(high_water[i]), 0);
        q_clear(i);
        sticky[i]    = 1'b0;
        model_max[i] = 0;
        dut_peak[i]  = 0;
      end else if (model_ok) begin
        int  sz;
        int  exp_hw;
        bit  exp_v;
        sz    = q_size(i);
        exp_v = (sz > 0) && ((i == 0) || (q_lastcnt(i) > 0) || (sz == DEPTH) || sticky[i]);
`ifdef AXI4_CHAN_BUFFER_STATS_EN
        exp_hw = model_max[i];
`else
        exp_hw = 0;
`endif
        chk("occupancy", i, 32'(occupancy[i]), sz);
        chk("in_ready", i, 32'(in_ready[i]), 32'(sz < DEPTH));
        chk("out_valid", i, 32'(out_valid[i]), 32'(exp_v));
        chk("high_water", i, 32'(high_water[i]), exp_hw);
        if (sticky[i]) chk("stable_beat", i, 32'({out_last[i], out_data[i]}), 32'(held_beat[i]));
        if (int'(occupancy[i]) > dut_peak[i]) dut_peak[i] = int'(occupancy[i]);
        if (out_valid[i] && out_ready[i]) begin
          if (sz == 0) chk("pop_from_empty", i, 32'(out_valid[i]), 0);
          else chk("out_beat", i, 32'({out_last[i], out_data[i]}), 32'(q_pop(i)));
        end
        if (in_valid[i] && in_ready[i]) q_push(i, {in_last[i], in_data[i]});
        sticky[i]    = out_valid[i] && !out_ready[i];
        held_beat[i] = {out_last[i], out_data[i]};
        if (q_size(i) > model_max[i]) model_max[i] = q_size(i);
      end
    end
    if (rst) model_ok = 1'b1;
  end

  // Downstream ready driver: 0 = stall, 1 = always ready, 2 = random 50%.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        case (ready_mode[i])
          2'd0:    out_ready[i] = 1'b0;
          2'd1:    out_ready[i] = 1'b1;
          default: out_ready[i] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic send(int i, logic [DW-1:0] d, logic l);
    bit ok;
    ok = 1'b0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_last[i]  = l;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready[i];
      @(posedge clk);
      #1;
    end
    in_valid[i] = 1'b0;
    chk("send_accept", i, 32'(ok), 1);
  endtask

  task automatic drain(int i);
    ready_mode[i] = 2'd1;
    for (int k = 0; k < 200 && q_size(i) != 0; k++) cycles(1);
    cycles(2);
    chk("drained", i, q_size(i), 0);
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;

    // Cut-through latency: three back-to-back beats with a free-running sink.
    ready_mode[0] = 2'd1;
    cycles(1);
    send(0, 16'h00A1, 1'b1);
    send(0, 16'h00A2, 1'b1);
    send(0, 16'h00A3, 1'b1);
    cycles(3);
    chk("peak_occ_cut_through", 0, dut_peak[0], 1);

    // Fill to full under backpressure, then one pop lets the fifth beat in.
    do_reset();
    ready_mode[0] = 2'd0;
    cycles(1);
    for (int b = 0; b < 4; b++) send(0, 16'h00B0 + 16'(b), 1'b1);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h00B4;
    in_last[0]  = 1'b1;
    @(negedge clk);
    chk("full_in_ready", 0, 32'(in_ready[0]), 0);
    chk("full_occupancy", 0, 32'(occupancy[0]), DEPTH);
    @(posedge clk);
    #1;
    ready_mode[0] = 2'd1;
    @(negedge clk);
    chk("prepop_in_ready", 0, 32'(in_ready[0]), 0);
    @(negedge clk);
    chk("fifth_accept", 0, 32'(in_ready[0]), 1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    drain(0);

    // Store-and-forward: a 3-beat burst is held until its last beat is stored.
    do_reset();
    ready_mode[1] = 2'd1;
    cycles(1);
    send(1, 16'h0010, 1'b0);
    send(1, 16'h0011, 1'b0);
    send(1, 16'h0012, 1'b1);
    drain(1);

    // Burst longer than DEPTH: the full escape must keep it flowing.
    do_reset();
    ready_mode[1] = 2'd1;
    cycles(1);
    for (int b = 0; b < 6; b++) send(1, 16'h0020 + 16'(b), 1'(b == 5));
    drain(1);
    chk("peak_occ_long_burst", 1, dut_peak[1], DEPTH);

    // Reset with two beats stored discards them.
    do_reset();
    ready_mode[0] = 2'd0;
    cycles(1);
    send(0, 16'h00C0, 1'b0);
    send(0, 16'h00C1, 1'b1);
    @(negedge clk);
    chk("pre_reset_occupancy", 0, 32'(occupancy[0]), 2);
`ifdef AXI4_CHAN_BUFFER_STATS_EN
    chk("pre_reset_high_water", 0, 32'(high_water[0]), 2);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_occupancy", 0, 32'(occupancy[0]), 0);
    chk("post_reset_out_valid", 0, 32'(out_valid[0]), 0);
    chk("post_reset_in_ready", 0, 32'(in_ready[0]), 1);
    chk("post_reset_high_water", 0, 32'(high_water[0]), 0);
    ready_mode[0] = 2'd1;
    cycles(4);

    // Random traffic on both instances.
    for (int i = 0; i < 2; i++) begin
      do_reset();
      ready_mode[i] = 2'd2;
      for (int b = 0; b < 1000; b++) begin
        logic [31:0] r;
        logic        l;
        while ($urandom_range(0, 1) == 0) cycles(1);
        r = $urandom();
        l = (b == 999) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
        send(i, r[DW-1:0], l);
      end
      drain(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
